// File: rtl/tile_vram_if.sv
// Display-scan, game-write and tile-RAM signals shared by the tile VRAM arbiter.
// slave is the arbiter side; master is the vga/game/RAM environment.
interface tile_vram_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) ();
  logic [10:0]       hcounter;
  logic [10:0]       vcounter;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] tile_code;
  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  hcounter, vcounter, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_re, mem_we, mem_wdata, tile_code, fifo_count
  );

  modport master (
    output hcounter, vcounter, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_re, mem_we, mem_wdata, tile_code, fifo_count
  );
endinterface

// File: rtl/tile_vram_arbiter.sv
// Single-port tile-map RAM arbiter: display fetches have absolute priority,
// queued game writes drain in free cycles (optionally only during vblank).
//
// state   | meaning
// S_IDLE  | no RAM operation this cycle
// S_FETCH | display read of one tile code (mem_re)
// S_WRITE | FIFO head written to RAM (mem_we)
module tile_vram_arbiter #(
  parameter int HLINES     = 640,
  parameter int VLINES     = 480,
  parameter int HLAST      = 800,
  parameter int VLAST      = 525,
  parameter int TILE_SH    = 4,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_VBLANK  = 1
) (
  input logic        pixel_clk,
  input logic        rst,
  tile_vram_if.slave bus
);
  localparam int TILES_X = HLINES >> TILE_SH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Encoding puts each strobe on its own state bit so mem_re/mem_we are flop outputs.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_WRITE = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [11:0]       h_plus3;
  logic [11:0]       col_idx;
  logic [10:0]       next_line;
  logic [10:0]       fetch_row;
  logic [11:0]       fetch_col;
  logic [ADDR_W-1:0] fetch_addr;
  logic              col_slot, line_slot, fetch_slot, wr_window;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+DATA_W-1:0] head;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count_q;
  logic                     push, pop;
  logic                     rd_pend;

  // Slot decode: column c is fetched three cycles before its first pixel.
  always_comb begin
    h_plus3   = {1'b0, bus.hcounter} + 12'd3;
    col_idx   = h_plus3 >> TILE_SH;
    next_line = (bus.vcounter == 11'(VLAST)) ? 11'd0 : bus.vcounter + 11'd1;
    col_slot  = (h_plus3[TILE_SH-1:0] == '0) && (col_idx >= 12'd1) &&
                (col_idx < 12'(TILES_X)) && (bus.vcounter < 11'(VLINES));
    line_slot = (bus.hcounter == 11'(HLAST - 2)) && (next_line < 11'(VLINES));
    fetch_slot = col_slot || line_slot;
    fetch_col  = col_slot ? col_idx : 12'd0;
    fetch_row  = line_slot ? (next_line >> TILE_SH) : (bus.vcounter >> TILE_SH);
    fetch_addr = ADDR_W'({1'b0, fetch_row} * 12'(TILES_X) + fetch_col);
    wr_window  = (WR_VBLANK == 0) || (bus.vcounter >= 11'(VLINES));
  end

  always_comb begin
    state_d = S_IDLE;
    if (fetch_slot) begin
      state_d = S_FETCH;
    end else if ((count_q != '0) && wr_window) begin
      state_d = S_WRITE;
    end
  end

  assign bus.wr_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign bus.fifo_count = count_q;
  assign push           = bus.wr_req && bus.wr_ready;
  assign pop            = (state_d == S_WRITE);
  assign head           = fifo_mem[rd_ptr];

  always_ff @(posedge pixel_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.tile_code <= '0;
      rd_pend       <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_pend <= (state_q == S_FETCH);
      if (rd_pend) bus.tile_code <= bus.mem_rdata;
      case (state_d)
        S_FETCH: bus.mem_addr <= fetch_addr;
        S_WRITE: begin
          bus.mem_addr  <= head[ADDR_W+DATA_W-1:DATA_W];
          bus.mem_wdata <= head[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_re = state_q[0];
  assign bus.mem_we = state_q[1];
endmodule

// File: tb/tb_tile_vram_arbiter.sv
// Scoreboard bench for tile_vram_arbiter: a line/column reference model predicts RAM ops and
// tile codes, a negedge monitor compares them against the DUT and a behavioural RAM.
module tb_tile_vram_arbiter;
  typedef struct { int due; bit is_wr; int addr; int data; } op_t;
  typedef struct { int due; int val; } tile_t;
  typedef struct { int addr; int data; } wr_t;

  logic pixel_clk = 1'b0;
  logic rst;
  always #5 pixel_clk = ~pixel_clk;

  tile_vram_if bus ();
  tile_vram_if bus2 ();

  tile_vram_arbiter u_dut (.pixel_clk(pixel_clk), .rst(rst), .bus(bus));
  tile_vram_arbiter #(.WR_VBLANK(0)) u_dut2 (.pixel_clk(pixel_clk), .rst(rst), .bus(bus2));

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  logic [7:0] ram [0:1199];
  int         shadow [1200];
  op_t        exp_q [$];
  tile_t      tile_q [$];
  wr_t        model_q [$];
  bit         pend_valid = 1'b0;
  int         pend_addr = 0;
  int         pend_data = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tile-map RAM: synchronous single port, read data one cycle after mem_re.
  always @(posedge pixel_clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference fetch rule expressed in screen coordinates; -1 means no fetch.
  function automatic int model_fetch(input int h, input int v);
    int nl;
    if (v < 480 && h >= 13 && h <= 621 && (h + 3) % 16 == 0)
      return (v / 16) * 40 + (h + 3) / 16;
    if (h == 798) begin
      nl = (v == 525) ? 0 : v + 1;
      if (nl < 480) return (nl / 16) * 40;
    end
    return -1;
  endfunction

  task automatic step(input int h, input int v, input bit req_new);
    int  fa;
    bit  full;
    wr_t w;
    op_t o;
    tile_t t;
    @(posedge pixel_clk);
    #1;
    if (req_new && !pend_valid) begin
      pend_valid = 1'b1;
      pend_addr  = $urandom_range(0, 1199);
      pend_data  = $urandom_range(0, 255);
    end
    bus.hcounter = 11'(h);
    bus.vcounter = 11'(v);
    bus.wr_req   = pend_valid;
    bus.wr_addr  = 11'(pend_addr);
    bus.wr_data  = 8'(pend_data);
    full = (model_q.size() >= 4);
    check("wr_ready", bus.wr_ready, !full);
    check("fifo_count", bus.fifo_count, model_q.size());
    fa = model_fetch(h, v);
    if (fa >= 0) begin
      o.due = cyc + 1; o.is_wr = 1'b0; o.addr = fa; o.data = 0;
      exp_q.push_back(o);
      t.due = cyc + 3; t.val = shadow[fa];
      tile_q.push_back(t);
    end else if (model_q.size() > 0 && v >= 480) begin
      w = model_q.pop_front();
      o.due = cyc + 1; o.is_wr = 1'b1; o.addr = w.addr; o.data = w.data;
      exp_q.push_back(o);
      shadow[w.addr] = w.data;
    end
    if (pend_valid && !full) begin
      w.addr = pend_addr; w.data = pend_data;
      model_q.push_back(w);
      pend_valid = 1'b0;
    end
  endtask

  task automatic step2(input int h, input bit req);
    @(posedge pixel_clk);
    #1;
    bus2.hcounter = 11'(h);
    bus2.vcounter = 11'd0;
    bus2.wr_req   = req;
    bus2.wr_addr  = 11'd777;
    bus2.wr_data  = 8'hA7;
  endtask

  always @(negedge pixel_clk) begin : monitor
    op_t   o;
    tile_t t;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        o = exp_q.pop_front();
        check("op_missing_cycle", cyc, o.due);
      end
      if (bus.mem_re || bus.mem_we) begin
        if (bus.mem_we) wr_seen++;
        check("strobe_exclusive", {31'd0, bus.mem_re & bus.mem_we}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, bus.mem_we, bus.mem_re}, 0);
        end else begin
          o = exp_q.pop_front();
          check("op_cycle", cyc, o.due);
          check("op_kind_we", bus.mem_we, o.is_wr);
          check("op_addr", bus.mem_addr, o.addr);
          if (o.is_wr) check("op_wdata", bus.mem_wdata, o.data);
        end
      end
      while (tile_q.size() > 0 && tile_q[0].due <= cyc) begin
        t = tile_q.pop_front();
        if (t.due == cyc) check("tile_code", bus.tile_code, t.val);
        else check("tile_cycle", cyc, t.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    rst = 1'b1;
    bus.hcounter = '0; bus.vcounter = '0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.mem_rdata = '0;
    bus2.hcounter = '0; bus2.vcounter = '0; bus2.wr_req = 1'b0;
    bus2.wr_addr = '0; bus2.wr_data = '0; bus2.mem_rdata = '0;
    for (int i = 0; i < 1200; i++) begin
      ram[i]    = 8'($urandom_range(0, 255));
      shadow[i] = int'(ram[i]);
    end
    ram[82] = 8'h5A; shadow[82] = 'h5A;
    ram[0]  = 8'hC3; shadow[0]  = 'hC3;

    // Reset values
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_tile_code", bus.tile_code, 0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst2_wr_ready", bus2.wr_ready, 1);
    @(posedge pixel_clk);
    #1;
    rst = 1'b0;

    // First strobe of the line comes from the h=13 slot
    for (int h = 0; h <= 14; h++) step(h, 0, 1'b0);
    check("t1_first_re", bus.mem_re, 1);
    check("t1_first_addr", bus.mem_addr, 1);

    // WR_VBLANK=0 instance: a queued write yields to the h=45 fetch and goes next cycle
    step(700, 100, 1'b0);
    for (int h = 40; h <= 44; h++) step2(h, h == 44);
    step2(45, 1'b0);
    check("t5_count", bus2.fifo_count, 1);
    step2(46, 1'b0);
    check("t5_re", bus2.mem_re, 1);
    check("t5_we_low", bus2.mem_we, 0);
    check("t5_fetch_addr", bus2.mem_addr, 3);
    step2(47, 1'b0);
    check("t5_we", bus2.mem_we, 1);
    check("t5_re_low", bus2.mem_re, 0);
    check("t5_wr_addr", bus2.mem_addr, 777);
    check("t5_wr_data", bus2.mem_wdata, 'hA7);
    step2(48, 1'b0);
    check("t5_count_after", bus2.fifo_count, 0);

    // Column fetch on line 32, column 2
    for (int h = 0; h <= 50; h++) begin
      step(h, 32, 1'b0);
      if (h == 30) begin
        check("t2_re", bus.mem_re, 1);
        check("t2_addr", bus.mem_addr, 82);
      end
      if (h == 40) check("t2_tile", bus.tile_code, 'h5A);
    end

    // Line-wrap fetch: suppressed going into vblank, taken at the frame wrap
    for (int h = 790; h <= 800; h++) begin
      step(h, 479, 1'b0);
      if (h == 799) check("t3_no_fetch", bus.mem_re, 0);
    end
    for (int h = 790; h <= 800; h++) step(h, 525, 1'b0);
    step(0, 0, 1'b0);
    check("t3_tile_line0", bus.tile_code, 'hC3);

    // Fill the FIFO outside vblank, then drain at vcounter=480
    for (int i = 0; i < 5; i++) step(100 + i, 100, 1'b1);
    step(105, 100, 1'b0);
    check("t4_full_count", bus.fifo_count, 4);
    check("t4_full_ready", bus.wr_ready, 0);
    wr_base = wr_seen;
    for (int h = 0; h < 10; h++) step(h, 480, 1'b0);
    check("t4_drained_writes", wr_seen - wr_base, 5);
    check("t4_empty", bus.fifo_count, 0);

    // Reset with queued writes and a fetch in flight
    for (int h = 0; h < 3; h++) step(h, 100, 1'b1);
    step(3, 100, 1'b0);
    check("t6_queued", bus.fifo_count, 3);
    step(28, 32, 1'b0);
    step(29, 32, 1'b0);
    step(30, 32, 1'b0);
    check("t6_re_pre", bus.mem_re, 1);
    rst = 1'b1;
    pend_valid = 1'b0;
    bus.wr_req = 1'b0;
    @(posedge pixel_clk);
    #1;
    check("t6_count", bus.fifo_count, 0);
    check("t6_re", bus.mem_re, 0);
    check("t6_we", bus.mem_we, 0);
    check("t6_tile", bus.tile_code, 0);
    check("t6_ready", bus.wr_ready, 1);
    exp_q.delete();
    tile_q.delete();
    model_q.delete();
    rst = 1'b0;
    wr_base = wr_seen;
    for (int h = 0; h <= 20; h++) step(h, 480, 1'b0);
    check("t6_no_stale_write", wr_seen - wr_base, 0);
    check("t6_tile_held", bus.tile_code, 0);

    // Randomized scan lines with random game writes
    for (int l = 0; l < 10; l++) begin
      int v;
      v = (l == 0) ? 479 : (l == 1) ? 525 : (l == 2) ? 480 : int'($urandom_range(0, 525));
      for (int h = 0; h <= 800; h++) step(h, v, $urandom_range(0, 2) == 0);
    end
    for (int i = 0; i < 12; i++) step(700, 500, 1'b0);
    check("end_ops_drained", exp_q.size(), 0);
    check("end_tiles_drained", tile_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
